// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle PC controller: opcodes, FSM states,
// ALU operation selects and the opcode-to-instruction-class decode.
package ctrl_pkg;

   // Opcodes
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   // FSM state encoding
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_COMMIT = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;

   // ALU operation selects
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_INC  = 3'b001;
   localparam logic [2:0] ALU_NEG  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_SVPC = 3'b100;
   localparam logic [2:0] ALU_PASS = 3'b111;

   // Instruction classes; each class has one fixed state path
   typedef enum logic [3:0] {
      ClsNop, ClsAlu, ClsSvpc, ClsLd, ClsSt, ClsJ, ClsBrz, ClsBrn, ClsJm
   } op_class_e;

   // Unlisted opcodes fall through to NOP
   function automatic op_class_e decode_op(input logic [3:0] op);
      case (op)
         OP_ADD, OP_INC, OP_NEG, OP_SUB: decode_op = ClsAlu;
         OP_SVPC: decode_op = ClsSvpc;
         OP_LD:   decode_op = ClsLd;
         OP_ST:   decode_op = ClsSt;
         OP_J:    decode_op = ClsJ;
         OP_BRZ:  decode_op = ClsBrz;
         OP_BRN:  decode_op = ClsBrn;
         OP_JM:   decode_op = ClsJm;
         default: decode_op = ClsNop;
      endcase
   endfunction

   // ALU select used during EXEC; memory ops pass the address through
   function automatic logic [2:0] alu_sel(input logic [3:0] op);
      case (op)
         OP_ADD:               alu_sel = ALU_ADD;
         OP_INC:               alu_sel = ALU_INC;
         OP_NEG:               alu_sel = ALU_NEG;
         OP_SUB:               alu_sel = ALU_SUB;
         OP_SVPC:              alu_sel = ALU_SVPC;
         OP_LD, OP_ST, OP_JM:  alu_sel = ALU_PASS;
         default:              alu_sel = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the budget is used up.
module mem_wait_timer #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] r_count;

   // Wait-cycle counter: cleared whenever the request completes or no request is pending
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Expires on the WAIT_MAX-th consecutive wait cycle
   assign o_expired = i_enable && (r_count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_pc_controller.sv
// Multi-cycle control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB/COMMIT, owns the N/Z flags and drives PC-source controls.
module multicycle_pc_controller
   import ctrl_pkg::*;
#(
   parameter int unsigned OPW      = 4,
   parameter int unsigned ALUOPW   = 3,
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic              inClk,
   input  logic              inReset,
   input  logic [OPW-1:0]    inOpcode,
   input  logic              inALUN,
   input  logic              inALUZ,
   input  logic              inMemReady,
   output logic              outIRWrite,
   output logic              outPCWrite,
   output logic              outRegWrite,
   output logic              outMemRead,
   output logic              outMemWrite,
   output logic [ALUOPW-1:0] outALUOp,
   output logic              outBranchNeg,
   output logic              outBranchZero,
   output logic              outJump,
   output logic              outJumpMem,
   output logic              outFlagN,
   output logic              outFlagZ,
   output logic              outFault
);

   logic [2:0] r_state;
   logic [2:0] w_state_next;
   logic       r_flag_n;
   logic       r_flag_z;
   op_class_e  w_cls;
   logic       w_wait_state;
   logic       w_expired;

   assign w_cls        = decode_op(inOpcode);
   assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM);

   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_timer (
      .i_clk     (inClk),
      .i_reset   (inReset),
      .i_clear   (!w_wait_state || inMemReady),
      .i_enable  (w_wait_state && !inMemReady),
      .o_expired (w_expired)
   );

   // Next-state selection along the per-class instruction path
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (inMemReady)     w_state_next = ST_DECODE;
            else if (w_expired) w_state_next = ST_HALT;
         end
         ST_DECODE: w_state_next = (w_cls == ClsNop) ? ST_COMMIT : ST_EXEC;
         ST_EXEC: begin
            case (w_cls)
               ClsLd, ClsSt, ClsJm: w_state_next = ST_MEM;
               ClsAlu, ClsSvpc:     w_state_next = ST_WB;
               default:             w_state_next = ST_COMMIT;
            endcase
         end
         ST_MEM: begin
            if (inMemReady)     w_state_next = (w_cls == ClsLd) ? ST_WB : ST_COMMIT;
            else if (w_expired) w_state_next = ST_HALT;
         end
         ST_WB:     w_state_next = ST_COMMIT;
         ST_COMMIT: w_state_next = ST_FETCH;
         ST_HALT:   w_state_next = ST_HALT;
         default:   w_state_next = ST_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge inClk) begin
      if (inReset) r_state <= ST_FETCH;
      else         r_state <= w_state_next;
   end

   // Flag register: only arithmetic instructions update N/Z, at the end of EXEC
   always_ff @(posedge inClk) begin
      if (inReset) begin
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else if ((r_state == ST_EXEC) && (w_cls == ClsAlu)) begin
         r_flag_n <= inALUN;
         r_flag_z <= inALUZ;
      end
   end

   // Output decode; reset forces everything low so an in-flight request drops immediately
   always_comb begin
      outIRWrite    = 1'b0;
      outPCWrite    = 1'b0;
      outRegWrite   = 1'b0;
      outMemRead    = 1'b0;
      outMemWrite   = 1'b0;
      outALUOp      = '0;
      outBranchNeg  = 1'b0;
      outBranchZero = 1'b0;
      outJump       = 1'b0;
      outJumpMem    = 1'b0;
      outFlagN      = 1'b0;
      outFlagZ      = 1'b0;
      outFault      = 1'b0;
      if (!inReset) begin
         outFlagN = r_flag_n;
         outFlagZ = r_flag_z;
         case (r_state)
            ST_FETCH: begin
               outMemRead = 1'b1;
               outIRWrite = inMemReady;
            end
            ST_EXEC: outALUOp = alu_sel(inOpcode);
            ST_MEM: begin
               outMemRead  = (w_cls == ClsLd) || (w_cls == ClsJm);
               outMemWrite = (w_cls == ClsSt);
            end
            ST_WB: outRegWrite = 1'b1;
            ST_COMMIT: begin
               outPCWrite    = 1'b1;
               outJump       = (w_cls == ClsJ);
               outBranchZero = (w_cls == ClsBrz);
               outBranchNeg  = (w_cls == ClsBrn);
               outJumpMem    = (w_cls == ClsJm);
            end
            ST_HALT: outFault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_pc_controller.sv
// Scoreboard bench: the driver pushes the expected output vector for every cycle it
// drives, and a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_pc_controller;

   localparam int unsigned OPW      = 4;
   localparam int unsigned ALUOPW   = 3;
   localparam int unsigned WAIT_MAX = 4;

   // Expected control word layout: {irw, pcw, rw, mrd, mwr, alu[2:0], bn, bz, j, jm}
   localparam logic [11:0] K_IRW = 12'h800;
   localparam logic [11:0] K_PCW = 12'h400;
   localparam logic [11:0] K_RW  = 12'h200;
   localparam logic [11:0] K_MRD = 12'h100;
   localparam logic [11:0] K_MWR = 12'h080;
   localparam logic [11:0] K_BN  = 12'h008;
   localparam logic [11:0] K_BZ  = 12'h004;
   localparam logic [11:0] K_J   = 12'h002;
   localparam logic [11:0] K_JM  = 12'h001;

   logic              inClk = 1'b0;
   logic              inReset;
   logic [OPW-1:0]    inOpcode;
   logic              inALUN, inALUZ, inMemReady;
   logic              outIRWrite, outPCWrite, outRegWrite, outMemRead, outMemWrite;
   logic [ALUOPW-1:0] outALUOp;
   logic              outBranchNeg, outBranchZero, outJump, outJumpMem;
   logic              outFlagN, outFlagZ, outFault;

   typedef struct {
      string       tag;
      logic [14:0] v;
   } sb_t;

   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic m_n = 1'b0;
   logic m_z = 1'b0;

   always #5 inClk = ~inClk;

   multicycle_pc_controller #(
      .OPW      (OPW),
      .ALUOPW   (ALUOPW),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .inClk         (inClk),
      .inReset       (inReset),
      .inOpcode      (inOpcode),
      .inALUN        (inALUN),
      .inALUZ        (inALUZ),
      .inMemReady    (inMemReady),
      .outIRWrite    (outIRWrite),
      .outPCWrite    (outPCWrite),
      .outRegWrite   (outRegWrite),
      .outMemRead    (outMemRead),
      .outMemWrite   (outMemWrite),
      .outALUOp      (outALUOp),
      .outBranchNeg  (outBranchNeg),
      .outBranchZero (outBranchZero),
      .outJump       (outJump),
      .outJumpMem    (outJumpMem),
      .outFlagN      (outFlagN),
      .outFlagZ      (outFlagZ),
      .outFault      (outFault)
   );

   task automatic check_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected vector: control word plus the modelled flags and fault
   function automatic logic [14:0] ev(input logic [11:0] c, input logic f);
      return {c, m_n, m_z, f};
   endfunction

   function automatic logic [11:0] alu_word(input logic [2:0] a);
      return {5'b0, a, 4'b0};
   endfunction

   // Push one expected cycle, then advance to just after the next rising edge
   task automatic step(input logic [14:0] e, input string tag);
      sb_q.push_back('{tag, e});
      @(posedge inClk);
      #1;
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation
   always @(negedge inClk) begin
      if (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check_eq(e.tag, {outIRWrite, outPCWrite, outRegWrite, outMemRead, outMemWrite, outALUOp,
                          outBranchNeg, outBranchZero, outJump, outJumpMem,
                          outFlagN, outFlagZ, outFault}, e.v);
      end
   end

   // One complete instruction with fw fetch waits and mw memory waits; n/z are the
   // ALU outputs presented during EXEC.
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                            input logic n, input logic z);
      logic [2:0]  alu;
      logic [11:0] cmt;
      bit is_nop, is_alu, has_wb, has_mem, mem_wr;
      alu = 3'b000; cmt = K_PCW;
      is_nop = 0; is_alu = 0; has_wb = 0; has_mem = 0; mem_wr = 0;
      case (op)
         4'b0100: begin alu = 3'b000; is_alu = 1; has_wb = 1; end
         4'b0101: begin alu = 3'b001; is_alu = 1; has_wb = 1; end
         4'b0110: begin alu = 3'b010; is_alu = 1; has_wb = 1; end
         4'b0111: begin alu = 3'b011; is_alu = 1; has_wb = 1; end
         4'b1111: begin alu = 3'b100; has_wb = 1; end
         4'b1110: begin alu = 3'b111; has_mem = 1; has_wb = 1; end
         4'b0011: begin alu = 3'b111; has_mem = 1; mem_wr = 1; end
         4'b1010: begin alu = 3'b111; has_mem = 1; cmt = K_PCW | K_JM; end
         4'b1000: cmt = K_PCW | K_J;
         4'b1001: cmt = K_PCW | K_BZ;
         4'b1011: cmt = K_PCW | K_BN;
         default: is_nop = 1;
      endcase
      inOpcode = op;
      for (int i = 0; i <= fw; i++) begin
         inMemReady = (i == fw);
         step(ev(K_MRD | ((i == fw) ? K_IRW : 12'h0), 1'b0), "fetch");
      end
      inMemReady = 1'b1;  // must be ignored outside FETCH/MEM
      step(ev(12'h0, 1'b0), "decode");
      if (!is_nop) begin
         inALUN = n;
         inALUZ = z;
         step(ev(alu_word(alu), 1'b0), "exec");
         if (is_alu) begin
            m_n = n;
            m_z = z;
         end
         inALUN = ~n;
         inALUZ = ~z;
         if (has_mem) begin
            for (int i = 0; i <= mw; i++) begin
               inMemReady = (i == mw);
               step(ev(mem_wr ? K_MWR : K_MRD, 1'b0), "mem");
            end
            inMemReady = 1'b1;
         end
         if (has_wb) step(ev(K_RW, 1'b0), "wb");
      end
      step(ev(cmt, 1'b0), "commit");
   endtask

   initial begin
      inReset    = 1'b1;
      inOpcode   = '0;
      inALUN     = 1'b0;
      inALUZ     = 1'b0;
      inMemReady = 1'b1;
      @(posedge inClk);
      #1;
      step(15'h0, "reset0");
      step(15'h0, "reset1");
      inReset = 1'b0;

      run_instr(4'b0000, 0, 0, 1'b1, 1'b1);  // NOP
      run_instr(4'b0111, 0, 0, 1'b1, 1'b0);  // SUB -> N=1 Z=0
      run_instr(4'b1011, 0, 0, 1'b0, 1'b1);  // BRN
      run_instr(4'b0100, 0, 0, 1'b0, 1'b1);  // ADD -> Z=1
      run_instr(4'b1001, 0, 0, 1'b1, 1'b0);  // BRZ
      run_instr(4'b0101, 0, 0, 1'b0, 1'b0);  // INC -> Z=0
      run_instr(4'b1001, 0, 0, 1'b1, 1'b1);  // BRZ
      run_instr(4'b1110, 0, 3, 1'b1, 1'b1);  // LD, 3 mem waits
      run_instr(4'b0011, 1, 1, 1'b1, 1'b1);  // ST
      run_instr(4'b1111, 0, 0, 1'b1, 1'b1);  // SVPC: flags held
      run_instr(4'b1000, 0, 0, 1'b1, 1'b1);  // J
      run_instr(4'b1010, 0, 0, 1'b1, 1'b1);  // JM
      run_instr(4'b1100, 0, 0, 1'b1, 1'b1);  // unused opcode -> NOP
      run_instr(4'b0000, 3, 0, 1'b0, 1'b0);  // 3 fetch waits: just under timeout
      run_instr(4'b0110, 0, 0, 1'b1, 1'b1);  // NEG -> N=1 Z=1

      // Reset held two cycles while an LD waits in MEM
      inOpcode   = 4'b1110;
      inMemReady = 1'b1;
      step(ev(K_MRD | K_IRW, 1'b0), "ld_fetch");
      step(ev(12'h0, 1'b0), "ld_decode");
      step(ev(alu_word(3'b111), 1'b0), "ld_exec");
      inMemReady = 1'b0;
      step(ev(K_MRD, 1'b0), "ld_mem_wait");
      inReset    = 1'b1;
      inMemReady = 1'b1;
      m_n = 1'b0;
      m_z = 1'b0;
      step(15'h0, "midreset0");
      step(15'h0, "midreset1");
      inReset = 1'b0;
      run_instr(4'b0000, 0, 0, 1'b0, 1'b0);

      // Memory never ready in FETCH: HALT after WAIT_MAX wait cycles
      inOpcode   = 4'b0000;
      inMemReady = 1'b0;
      for (int i = 0; i < int'(WAIT_MAX); i++) step(ev(K_MRD, 1'b0), "halt_wait");
      inMemReady = 1'b1;
      for (int i = 0; i < 3; i++) step(ev(12'h0, 1'b1), "halt");
      inReset = 1'b1;
      step(15'h0, "halt_reset");
      inReset = 1'b0;
      run_instr(4'b0101, 0, 0, 1'b1, 1'b0);  // INC after recovery

      @(negedge inClk);
      #1;
      check_eq("sb_drained", 15'(sb_q.size()), 15'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
